program_loader: RTL and testbench

//  Sequences program download into the CPU instruction store from a byte stream (UART RX or host bridge).

---
 rtl/program_loader.sv | 199 +++++++++++++++++++
 tb/tb_program_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module  : program_loader
// Purpose : Parses a framed byte-stream program image and writes it into the
//           CPU instruction store. Gates cpu_run until the checksum passes.
// Rev     : 1.0
// ============================================================================
module program_loader #(
  parameter int unsigned BASE_INDEX      = 0,
  parameter int unsigned MAX_WORDS       = 256,
  parameter int unsigned TIMEOUT_CYCLES  = 1000000,
  parameter logic [7:0]  SYNC_BYTE       = 8'hA5,
  parameter bit          RUN_AFTER_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        download_program_o,
  output logic [31:0] instruction_index_o,
  output logic [15:0] program_in_o,
  output logic        cpu_run_o,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic        load_error_o,
  output logic [1:0]  err_code_o
);

  localparam int unsigned   TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0]   c_base = 32'(BASE_INDEX);
  localparam logic [16:0]   c_max  = (MAX_WORDS > 65535) ? 17'h10000 : 17'(MAX_WORDS);
  localparam logic [TMR_W-1:0] c_tmo = TMR_W'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LEN_LO  = 4'd1,
    S_LEN_HI  = 4'd2,
    S_DATA_LO = 4'd3,
    S_DATA_HI = 4'd4,
    S_WRITE   = 4'd5,
    S_CHECK   = 4'd6,
    S_DONE    = 4'd7,
    S_ERROR   = 4'd8
  } state_t;

  state_t           state_q;
  logic             rx_ready_q;
  logic             download_q;
  logic [31:0]      index_q;
  logic [15:0]      prog_q;
  logic             cpu_run_q;
  logic             busy_q;
  logic             done_q;
  logic             error_q;
  logic [1:0]       err_code_q;
  logic [7:0]       acc_q;
  logic [31:0]      k_q;
  logic [15:0]      n_q;
  logic [7:0]       lo_q;
  logic [TMR_W-1:0] tmr_q;

  logic             w_accept;
  logic             w_timed;
  logic [15:0]      n_d;
  logic [7:0]       acc_d;
  logic [31:0]      k_d;
  logic [TMR_W-1:0] tmr_d;
  logic             err_go_d;
  logic [1:0]       err_code_d;

  assign w_accept = rx_valid_i & rx_ready_q;
  assign n_d      = {rx_data_i, n_q[7:0]};
  assign acc_d    = acc_q ^ rx_data_i;
  assign k_d      = k_q + 32'd1;
  assign tmr_d    = tmr_q + TMR_W'(1);
  assign w_timed  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA_LO) ||
                    (state_q == S_DATA_HI) || (state_q == S_CHECK);

  // All three abort causes funnel through one error entry path.
  always_comb begin
    err_go_d   = 1'b0;
    err_code_d = 2'b00;
    if (w_timed && !w_accept && (tmr_d == c_tmo)) begin
      err_go_d   = 1'b1;
      err_code_d = 2'b10;
    end else if (w_accept && (state_q == S_LEN_HI) && ({1'b0, n_d} > c_max)) begin
      err_go_d   = 1'b1;
      err_code_d = 2'b11;
    end else if (w_accept && (state_q == S_CHECK) && (rx_data_i != acc_q)) begin
      err_go_d   = 1'b1;
      err_code_d = 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rx_ready_q <= 1'b1;
      download_q <= 1'b0;
      index_q    <= c_base;
      prog_q     <= 16'h0000;
      cpu_run_q  <= RUN_AFTER_RESET;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'b00;
      acc_q      <= 8'h00;
      k_q        <= 32'd0;
      n_q        <= 16'h0000;
      lo_q       <= 8'h00;
      tmr_q      <= '0;
    end else if (err_go_d) begin
      state_q    <= S_ERROR;
      download_q <= 1'b0;
      cpu_run_q  <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b1;
      err_code_q <= err_code_d;
    end else begin
      if (w_timed) begin
        tmr_q <= w_accept ? '0 : tmr_d;
      end
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_accept && (rx_data_i == SYNC_BYTE)) begin
            state_q    <= S_LEN_LO;
            cpu_run_q  <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
            acc_q      <= 8'h00;
            k_q        <= 32'd0;
            tmr_q      <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            n_q[7:0] <= rx_data_i;
            acc_q    <= acc_d;
            state_q  <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            n_q     <= n_d;
            acc_q   <= acc_d;
            state_q <= (n_d == 16'h0000) ? S_CHECK : S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (w_accept) begin
            lo_q    <= rx_data_i;
            acc_q   <= acc_d;
            state_q <= S_DATA_HI;
          end
        end
        S_DATA_HI: begin
          if (w_accept) begin
            prog_q     <= {rx_data_i, lo_q};
            index_q    <= c_base + k_q;
            download_q <= 1'b1;
            acc_q      <= acc_d;
            rx_ready_q <= 1'b0;
            state_q    <= S_WRITE;
          end
        end
        S_WRITE: begin
          k_q        <= k_d;
          rx_ready_q <= 1'b1;
          state_q    <= (k_d < {16'h0000, n_q}) ? S_DATA_LO : S_CHECK;
        end
        S_CHECK: begin
          if (w_accept) begin
            state_q    <= S_DONE;
            download_q <= 1'b0;
            cpu_run_q  <= 1'b1;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_ready_o          = rx_ready_q;
  assign download_program_o  = download_q;
  assign instruction_index_o = index_q;
  assign program_in_o        = prog_q;
  assign cpu_run_o           = cpu_run_q;
  assign load_busy_o         = busy_q;
  assign load_done_o         = done_q;
  assign load_error_o        = error_q;
  assign err_code_o          = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_program_loader
// Purpose : Randomized frame stimulus against a frame-level reference model.
// Rev     : 1.0
// ============================================================================
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        dl;
  logic [31:0] idx;
  logic [15:0] prog;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  program_loader #(
    .BASE_INDEX(10), .MAX_WORDS(256), .TIMEOUT_CYCLES(50),
    .SYNC_BYTE(8'hA5), .RUN_AFTER_RESET(1'b0)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .download_program_o(dl), .instruction_index_o(idx), .program_in_o(prog),
    .cpu_run_o(cpu_run), .load_busy_o(busy), .load_done_o(done),
    .load_error_o(error), .err_code_o(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CPU instruction store as seen through the load port
  logic [15:0] mem [int unsigned];
  int first_dl = -1;
  int last_dl  = -1;
  always @(negedge clk) begin
    if (!rst && dl) begin
      mem[idx] = prog;
      if (first_dl < 0) first_dl = cyc;
      last_dl = cyc;
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Enter and leave at a negedge; rx_valid stays high afterwards.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
    bit rdy;
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 20 && !got; t++) begin
      rdy = rx_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
    end
    if (!got) check("rx_ready_timeout", 32'd0, 32'd1);
  endtask

  logic [7:0] fr[$];

  task automatic mk_frame(input int n, input bit bad);
    logic [7:0] x;
    fr = {8'hA5, 8'(n), 8'(n >> 8)};
    if (n > 256) return;
    x = 8'(n) ^ 8'(n >> 8);
    for (int i = 0; i < 2 * n; i++) begin
      fr.push_back(8'($urandom));
      x ^= fr[fr.size() - 1];
    end
    fr.push_back(bad ? ~x : x);
  endtask

  task automatic run_frame(input logic [7:0] f[$], input int gapmax);
    logic [7:0]  x;
    logic [1:0]  code;
    logic [15:0] w;
    int n, nw, c, c_first, c_last;
    mem.delete();
    first_dl = -1;
    last_dl  = -1;
    c_first  = -1;
    c_last   = -1;
    n = int'({f[2], f[1]});
    if (n > 256) begin
      code = 2'b11;
      nw   = 0;
    end else begin
      x = 8'h00;
      for (int i = 1; i < 3 + 2 * n; i++) x ^= f[i];
      code = (f[3 + 2 * n] == x) ? 2'b00 : 2'b01;
      nw   = n;
    end
    for (int i = 0; i < f.size(); i++) begin
      send_byte(f[i], (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0, c);
      if (i == 4) c_first = c;
      c_last = c;
    end
    rx_valid = 1'b0;
    if (code == 2'b11) check("len_err_next_cycle", 32'(err_code), 32'd3);
    repeat (2) @(negedge clk);
    check("err_code", 32'(err_code), 32'(code));
    check("load_done", 32'(done), 32'(code == 2'b00));
    check("load_error", 32'(error), 32'(code != 2'b00));
    check("cpu_run", 32'(cpu_run), 32'(code == 2'b00));
    check("dl_after", 32'(dl), 32'd0);
    check("busy_after", 32'(busy), 32'd0);
    check("word_count", 32'(mem.size()), 32'(nw));
    if (nw > 0) begin
      check("dl_first", 32'(first_dl), 32'(c_first));
      check("dl_last", 32'(last_dl), 32'(c_last - 1));
    end else begin
      check("no_dl", 32'(first_dl), 32'hFFFF_FFFF);
    end
    for (int i = 0; i < nw; i++) begin
      w = {f[4 + 2 * i], f[3 + 2 * i]};
      if (mem.exists(32'(10 + i))) check("word", 32'(mem[32'(10 + i)]), 32'(w));
      else check("word_missing", 32'd0, 32'd1);
    end
  endtask

  task automatic send_junk(input int cnt);
    logic [7:0] j;
    int c;
    for (int i = 0; i < cnt; i++) begin
      j = 8'($urandom);
      if (j == 8'hA5) j = 8'h00;
      send_byte(j, 0, c);
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int c;
    logic [7:0] x;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_dl", 32'(dl), 32'd0);
    check("rst_idx", idx, 32'd10);
    check("rst_prog", 32'(prog), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_flags", {29'd0, busy, done, error}, 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);

    // Example image: two halfwords, checksum from the XOR rule
    fr = {8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F};
    x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x ^= fr[i];
    fr.push_back(x);
    run_frame(fr, 0);
    check("ex_word0", 32'(mem[32'd10]), 32'h2005);
    check("ex_word1", 32'(mem[32'd11]), 32'h1FC2);

    fr[7] = 8'h00;
    run_frame(fr, 0);

    fr = {8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame(fr, 0);

    fr = {8'hA5, 8'h01, 8'h01};
    run_frame(fr, 0);
    mk_frame(3, 1'b0);
    run_frame(fr, 2);

    // Timeout: three data bytes then silence
    fr = {8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
    foreach (fr[i]) send_byte(fr[i], 0, c);
    rx_valid = 1'b0;
    repeat (49) @(negedge clk);
    check("tmo_before", 32'(err_code), 32'd0);
    check("tmo_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo_code", 32'(err_code), 32'd2);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_dl", 32'(dl), 32'd0);

    // Reset in DATA_HI after junk bytes
    send_junk(0);
    fr = {8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
    foreach (fr[i]) send_byte(fr[i], 0, c);
    rst = 1'b1;
    #1;
    check("mrst_dl", 32'(dl), 32'd0);
    check("mrst_rx_ready", 32'(rx_ready), 32'd1);
    check("mrst_idx", idx, 32'd10);
    check("mrst_prog", 32'(prog), 32'd0);
    check("mrst_flags", {28'd0, busy, done, error, cpu_run}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    fr = {8'hA5, 8'h03, 8'h00, 8'hA5, 8'hA5, 8'h01, 8'h02, 8'hA5, 8'h03};
    x = 8'h00;
    for (int i = 1; i < fr.size(); i++) x ^= fr[i];
    fr.push_back(x);
    run_frame(fr, 0);

    for (int r = 0; r < 12; r++) begin
      send_junk(int'($urandom_range(2, 0)));
      if ($urandom_range(7, 0) == 0) mk_frame(int'($urandom_range(400, 257)), 1'b0);
      else mk_frame(int'($urandom_range(5, 0)), ($urandom_range(3, 0) == 0));
      run_frame(fr, ($urandom_range(1, 0) == 1) ? 3 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
